// File: rtl/uvmt_cv32e40x_obi_data_slv.sv
// Behavioural OBI data-memory slave: grants address-phase requests, performs byte-enabled
// accesses on a word memory, and returns in-order response beats after a minimum latency.
module uvmt_cv32e40x_obi_data_slv #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_WORDS       = 1024,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RVALID_LATENCY  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  input  logic [5:0]            atop_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic                  err_o,
  output logic                  exokay_o,
  input  logic                  gnt_stall_i,
  input  logic                  rvalid_stall_i,
  output logic [3:0]            outstanding_o
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int WA_W  = ADDR_WIDTH - 2;

  // The transfer cycle itself counts as the first latency cycle, so a queued
  // entry waits two cycles less than the latency before it may pop.
  localparam logic [3:0]       WAIT_INIT = (RVALID_LATENCY > 1) ? 4'(RVALID_LATENCY - 2) : 4'd0;
  localparam logic [3:0]       MAX_CNT   = 4'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [WA_W-1:0]  MEM_LIMIT = WA_W'(MEM_WORDS);

  logic [31:0]      r_mem [MEM_WORDS];
  logic [31:0]      r_q_rdata [MAX_OUTSTANDING];
  logic             r_q_err [MAX_OUTSTANDING];
  logic             r_q_exokay [MAX_OUTSTANDING];
  logic [3:0]       r_q_wait [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [3:0]       r_count;

  logic [WA_W-1:0]  w_word_addr;
  logic [IDX_W-1:0] w_idx;
  logic             w_unused_addr;
  logic             w_transfer;
  logic             w_err;
  logic [31:0]      w_rdata;
  logic             w_exokay;
  logic             w_pop_q;
  logic             w_pop_byp;
  logic             w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_word_addr   = addr_i[ADDR_WIDTH-1:2];
  assign w_idx         = w_word_addr[IDX_W-1:0];
  assign w_unused_addr = ^addr_i[1:0];

  assign gnt_o      = rst_ni & req_i & ~gnt_stall_i & (r_count < MAX_CNT);
  assign w_transfer = req_i & gnt_o;
  assign w_err      = (w_word_addr >= MEM_LIMIT);
  assign w_rdata    = (w_err | we_i) ? 32'h0 : r_mem[w_idx];
  assign w_exokay   = (atop_i != 6'd0) & ~w_err;

  // With a one-cycle latency and an empty queue the new transfer is itself
  // the head, so it is answered straight away instead of being queued.
  assign w_pop_q   = (r_count != 4'd0) & (r_q_wait[r_rd_ptr] == 4'd0) & ~rvalid_stall_i;
  assign w_pop_byp = w_transfer & (r_count == 4'd0) & (RVALID_LATENCY == 1) & ~rvalid_stall_i;
  assign w_push    = w_transfer & ~w_pop_byp;

  assign outstanding_o = r_count;

  always_ff @(posedge clk_i) begin
    if (w_transfer && we_i && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_q_rdata[i]  <= '0;
        r_q_err[i]    <= 1'b0;
        r_q_exokay[i] <= 1'b0;
        r_q_wait[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (w_push && (r_wr_ptr == PTR_W'(i))) begin
          r_q_rdata[i]  <= w_rdata;
          r_q_err[i]    <= w_err;
          r_q_exokay[i] <= w_exokay;
          r_q_wait[i]   <= WAIT_INIT;
        end else if (r_q_wait[i] != 4'd0) begin
          r_q_wait[i] <= r_q_wait[i] - 4'd1;
        end
      end
      if (w_push)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_q) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + {3'b000, w_push} - {3'b000, w_pop_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      exokay_o <= 1'b0;
    end else if (w_pop_q) begin
      rvalid_o <= 1'b1;
      rdata_o  <= r_q_rdata[r_rd_ptr];
      err_o    <= r_q_err[r_rd_ptr];
      exokay_o <= r_q_exokay[r_rd_ptr];
    end else if (w_pop_byp) begin
      rvalid_o <= 1'b1;
      rdata_o  <= w_rdata;
      err_o    <= w_err;
      exokay_o <= w_exokay;
    end else begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      exokay_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_obi_data_slv.sv
// Bench for the OBI data slave: two instances (latency 1 and 3) checked every cycle against
// a timestamp-based response model, plus directed scenarios with literal expectations.
module tb_uvmt_cv32e40x_obi_data_slv;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int MAXO = 4;
  localparam int QD   = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        exok;
    logic [31:0] rdy;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req [2];
  logic        gnt [2];
  logic [31:0] addr [2];
  logic        we [2];
  logic [3:0]  be [2];
  logic [31:0] wdata [2];
  logic [5:0]  atop [2];
  logic        rvalid [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic        exok [2];
  logic        gstall [2];
  logic        rstall [2];
  logic [3:0]  outst [2];

  int n_checks = 0;
  int n_fail   = 0;

  // clock/reset block
  always #5 clk = ~clk;

  uvmt_cv32e40x_obi_data_slv #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .MAX_OUTSTANDING(MAXO),
                               .RVALID_LATENCY(LAT0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .atop_i(atop[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]), .exokay_o(exok[0]), .gnt_stall_i(gstall[0]),
    .rvalid_stall_i(rstall[0]), .outstanding_o(outst[0]));

  uvmt_cv32e40x_obi_data_slv #(.ADDR_WIDTH(32), .MEM_WORDS(1024), .MAX_OUTSTANDING(MAXO),
                               .RVALID_LATENCY(LAT1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .atop_i(atop[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]), .exokay_o(exok[1]), .gnt_stall_i(gstall[1]),
    .rvalid_stall_i(rstall[1]), .outstanding_o(outst[1]));

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h want %h at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: each accepted request becomes an entry stamped with the earliest cycle it may answer.
  rsp_t        mq [2][QD];
  int          mhd [2];
  int          msz [2];
  logic [31:0] mm [2][1024];
  logic        e_rvalid [2];
  logic [31:0] e_rdata [2];
  logic        e_err [2];
  logic        e_exok [2];
  int unsigned cyc = 0;

  task automatic mdl_step(input int d, input logic g);
    rsp_t e;
    logic er;
    int   w;
    int   lat;
    lat = (d == 0) ? LAT0 : LAT1;
    if (req[d] && g) begin
      er     = (addr[d][31:2] >= 30'd1024);
      w      = int'(addr[d][11:2]);
      e.rdata = (er || we[d]) ? 32'h0 : mm[d][w];
      e.err   = er;
      e.exok  = (atop[d] != 6'd0) && !er;
      e.rdy   = cyc + lat - 1;
      mq[d][(mhd[d] + msz[d]) % QD] = e;
      msz[d]++;
      if (we[d] && !er)
        for (int k = 0; k < 4; k++)
          if (be[d][k]) mm[d][w][8*k +: 8] = wdata[d][8*k +: 8];
    end
    if (msz[d] > 0 && mq[d][mhd[d]].rdy <= cyc && !rstall[d]) begin
      e_rvalid[d] = 1'b1;
      e_rdata[d]  = mq[d][mhd[d]].rdata;
      e_err[d]    = mq[d][mhd[d]].err;
      e_exok[d]   = mq[d][mhd[d]].exok;
      mhd[d]      = (mhd[d] + 1) % QD;
      msz[d]--;
    end else begin
      e_rvalid[d] = 1'b0;
      e_rdata[d]  = 32'h0;
      e_err[d]    = 1'b0;
      e_exok[d]   = 1'b0;
    end
  endtask

  // compare process: inputs are driven on the falling edge, checked just after it
  always begin : compare
    logic eg;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        msz[d] = 0; mhd[d] = 0;
        e_rvalid[d] = 1'b0; e_rdata[d] = 32'h0; e_err[d] = 1'b0; e_exok[d] = 1'b0;
      end
      eg = rst_n[d] && req[d] && !gstall[d] && (msz[d] < MAXO);
      chk("rvalid", d, rvalid[d], e_rvalid[d]);
      chk("rdata", d, rdata[d], e_rdata[d]);
      chk("err", d, err[d], e_err[d]);
      chk("exokay", d, exok[d], e_exok[d]);
      chk("outstanding", d, outst[d], msz[d]);
      chk("gnt", d, gnt[d], eg);
      if (rst_n[d]) mdl_step(d, eg);
    end
    cyc++;
  end

  // driver tasks: always entered and left on a falling edge
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd, input logic [5:0] at);
    int n = 0;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd; atop[d] = at;
    #2;
    while (!gnt[d] && n < 100) begin
      @(negedge clk); #2; n++;
    end
    chk("grant_timeout", d, gnt[d], 1'b1);
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  task automatic expect_beat(input int d, input logic [31:0] rd, input logic er, input logic ex,
                             input int lat);
    int n = 0;
    #2;
    while (!rvalid[d] && n < 40) begin
      @(negedge clk); #2; n++;
    end
    chk("beat_seen", d, rvalid[d], 1'b1);
    chk("beat_rdata", d, rdata[d], rd);
    chk("beat_err", d, err[d], er);
    chk("beat_exokay", d, exok[d], ex);
    if (lat >= 0) chk("beat_latency", d, n, lat);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; be[d] = '0;
      wdata[d] = '0; atop[d] = '0; gstall[d] = 1'b0; rstall[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outstanding", 0, outst[0], 4'd0);
    chk("reset_rvalid", 1, rvalid[1], 1'b0);
    @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);

    // full write then read-back, one cycle after grant
    issue(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 6'h0);
    expect_beat(0, 32'h0, 1'b0, 1'b0, 0);
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0, 6'h0);
    expect_beat(0, 32'hDEADBEEF, 1'b0, 1'b0, 0);

    // partial write of byte 2
    issue(0, 1'b1, 32'h12, 4'b0100, 32'h00AA0000, 6'h0);
    expect_beat(0, 32'h0, 1'b0, 1'b0, 0);
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0, 6'h0);
    expect_beat(0, 32'hDEAABEEF, 1'b0, 1'b0, 0);

    // out-of-range accesses; the bad write would alias word 0 if not blocked
    issue(0, 1'b1, 32'h0, 4'b1111, 32'h12345678, 6'h0);
    expect_beat(0, 32'h0, 1'b0, 1'b0, 0);
    issue(0, 1'b0, 32'h1000, 4'b1111, 32'h0, 6'h0);
    expect_beat(0, 32'h0, 1'b1, 1'b0, 0);
    issue(0, 1'b1, 32'h1000, 4'b1111, 32'hFFFFFFFF, 6'h0);
    expect_beat(0, 32'h0, 1'b1, 1'b0, 0);
    issue(0, 1'b0, 32'h0, 4'b1111, 32'h0, 6'h0);
    expect_beat(0, 32'h12345678, 1'b0, 1'b0, 0);

    // atomic requests
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0, 6'h22);
    expect_beat(0, 32'hDEAABEEF, 1'b0, 1'b1, 0);
    issue(0, 1'b0, 32'h1000, 4'b1111, 32'h0, 6'h22);
    expect_beat(0, 32'h0, 1'b1, 1'b0, 0);

    // grant stall input
    gstall[0] = 1'b1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; atop[0] = 6'h0;
    #2;
    chk("gnt_stalled", 0, gnt[0], 1'b0);
    @(negedge clk);
    gstall[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0, 6'h0);
    expect_beat(0, 32'hDEAABEEF, 1'b0, 1'b0, 0);

    // fill the queue with responses held off
    for (int i = 0; i < 5; i++) begin
      issue(0, 1'b1, 32'h20 + 32'(4*i), 4'b1111, 32'hA0000000 + 32'(i), 6'h0);
      expect_beat(0, 32'h0, 1'b0, 1'b0, 0);
    end
    rstall[0] = 1'b1;
    for (int i = 0; i < 4; i++) issue(0, 1'b0, 32'h20 + 32'(4*i), 4'b1111, 32'h0, 6'h0);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h30;
    #2;
    chk("full_outstanding", 0, outst[0], 4'd4);
    chk("full_gnt", 0, gnt[0], 1'b0);
    @(negedge clk);
    #2;
    chk("full_gnt_hold", 0, gnt[0], 1'b0);
    @(negedge clk);
    rstall[0] = 1'b0;
    fork
      issue(0, 1'b0, 32'h30, 4'b1111, 32'h0, 6'h0);
      begin
        expect_beat(0, 32'hA0000000, 1'b0, 1'b0, 1);
        for (int i = 1; i < 4; i++) expect_beat(0, 32'hA0000000 + 32'(i), 1'b0, 1'b0, 0);
        expect_beat(0, 32'hA0000004, 1'b0, 1'b0, 0);
      end
    join

    // latency 3 instance
    issue(1, 1'b1, 32'h40, 4'b1111, 32'hCAFE0001, 6'h0);
    expect_beat(1, 32'h0, 1'b0, 1'b0, 2);
    issue(1, 1'b1, 32'h44, 4'b1111, 32'hCAFE0002, 6'h0);
    expect_beat(1, 32'h0, 1'b0, 1'b0, 2);
    issue(1, 1'b0, 32'h40, 4'b1111, 32'h0, 6'h0);
    issue(1, 1'b0, 32'h44, 4'b1111, 32'h0, 6'h0);
    #2;
    chk("l3_early", 1, rvalid[1], 1'b0);
    @(negedge clk); #2;
    chk("l3_first_rvalid", 1, rvalid[1], 1'b1);
    chk("l3_first_rdata", 1, rdata[1], 32'hCAFE0001);
    @(negedge clk); #2;
    chk("l3_second_rvalid", 1, rvalid[1], 1'b1);
    chk("l3_second_rdata", 1, rdata[1], 32'hCAFE0002);
    @(negedge clk);

    // reset while two reads are in flight
    issue(1, 1'b0, 32'h40, 4'b1111, 32'h0, 6'h0);
    issue(1, 1'b0, 32'h44, 4'b1111, 32'h0, 6'h0);
    rst_n[1] = 1'b0;
    #2;
    chk("rst_outstanding", 1, outst[1], 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("post_rst_rvalid", 1, rvalid[1], 1'b0);
      chk("post_rst_outstanding", 1, outst[1], 4'd0);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
